rr_arbiter_4: RTL and testbench
===============================

# rr_arbiter_4

Four-requester round-robin arbiter that shares one resource and presents its grant both as a 2-bit index and as a one-hot vector, produced by a 2-to-4 decode of the index. It is the scheduling front end for the decoder datapath: requesters assert `req`, the arbiter selects one owner, and the owner keeps the grant until it releases it. Each grant change takes one clock. Fairness comes from a rotating priority pointer.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per owner when the hold limit is compiled in. Legal range 2..15.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  4  request lines; bit i is requester i. Level-sensitive.
- `gnt`  out  4  one-hot grant; equals decode(`gnt_id`) when `gnt_valid`=1, else 4'b0000.
- `gnt_id`  out  2  index of the current owner; holds its last value when idle.
- `gnt_valid`  out  1  1 while a grant is active.

## Operation
- State machine with two states, IDLE and GRANT. `ptr[1:0]` is the rotating priority pointer.
- Reset: state=IDLE, `gnt`=0000, `gnt_id`=00, `gnt_valid`=0, `ptr`=00, `hold_cnt`=0.
- Winner selection: the first set bit of `req`, scanning `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4).
- IDLE:
  - If `req`=0000, stay in IDLE.
  - Otherwise, on the next edge: register the winner into `gnt_id`, set `gnt_valid`=1, set `ptr`=winner+1 (mod 4, so 3 wraps to 0), clear `hold_cnt`, and go to GRANT.
- GRANT:
  - While `req[gnt_id]`=1, hold the grant unchanged.
  - When `req[gnt_id]`=0 and other requests are pending, hand over to the next winner on the next edge. There is no idle bubble.
  - When `req[gnt_id]`=0 and `req`=0000, go to IDLE on the next edge and clear `gnt_valid`.
- `gnt` is always derived from the registered `gnt_id` and `gnt_valid`, so it is glitch-free and never has more than one bit set.
- Simultaneous release and new request in the same cycle: the releasing bit is already 0, so it is excluded by the scan.
- Requests that appear mid-grant never preempt the owner, except through the hold limit.
- Reset asserted mid-grant: all outputs return to reset values immediately (asynchronous). Arbitration resumes from `ptr`=0 after reset deasserts.

## Timing
- Grant latency: 1 cycle from the sampling edge on which `req` is seen to the edge on which `gnt_valid`/`gnt` are updated.
- Release latency: 1 cycle from `req[gnt_id]` falling to the handover or to `gnt_valid`=0.
- A single requester holding `req` high keeps the grant indefinitely when `HOLD_LIMIT_EN` is undefined.
- Back-to-back handovers produce a new owner every cycle if each owner releases immediately.

## Configuration
- `RR_ARBITER_HOLD_LIMIT_EN` defined:
  - A 4-bit `hold_cnt` increments on each GRANT cycle and is cleared on every new grant.
  - When `hold_cnt`=`MAX_HOLD`-1, `req[gnt_id]` is still 1, and any other `req` bit is 1, the grant is revoked on the next edge and passed to the next winner in rotating order.
  - If no other request is pending, the owner keeps the grant and `hold_cnt` saturates at `MAX_HOLD`-1.
- `RR_ARBITER_HOLD_LIMIT_EN` undefined:
  - No counter is built.
  - A grant ends only when the owner releases it.

## Test plan
- Reset then single request: assert `rst`, release it, drive `req`=0001 -> after 1 edge, `gnt`=0001, `gnt_id`=00, `gnt_valid`=1. Drop `req` -> after 1 edge, `gnt_valid`=0 and `gnt`=0000.
- Full contention rotation: drive `req`=1111 with `ptr`=0, and have each owner drop its bit for one cycle after 2 grant cycles -> grant order 0,1,2,3,0 with no idle cycle between owners.
- Wrap-around: with `ptr`=3 after granting requester 2, drive `req`=0101 -> grant goes to 0 (scan 3,0), then to 2.
- Async reset mid-grant: owner 2 active, pulse `rst` between clock edges -> `gnt`=0000, `gnt_valid`=0, `gnt_id`=00 with no clock edge. Next grant with `req`=1100 goes to 2.
- One-hot check: random `req` for 1000 cycles -> `gnt`==decode(`gnt_id`) whenever `gnt_valid`, popcount(`gnt`)≤1, and no requester is starved for more than 3 owner turns.
- Hold limit (`RR_ARBITER_HOLD_LIMIT_EN`, `MAX_HOLD`=4): `req`=0011 held constant -> owner 0 for 4 cycles, then owner 1 for 4 cycles, alternating. With `req`=0001 alone -> owner 0 held indefinitely.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-requester round-robin arbiter; the owner keeps the grant until it releases.
// Define RR_ARBITER_HOLD_LIMIT_EN to revoke a contended grant after MAX_HOLD cycles.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t     state_q;
  logic [1:0] ptr_q;
  logic [1:0] gnt_id_q;
  logic       gnt_valid_q;

  logic [3:0] owner_mask;
  logic [3:0] scan_req;
  logic [1:0] win;
  logic       win_found;
  logic       hold_expired;
  logic       grant_new;
  logic       release_idle;

  if (MAX_HOLD < 2 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("rr_arbiter_4: MAX_HOLD must be within 2..15");
  end

`ifdef RR_ARBITER_HOLD_LIMIT_EN
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
  logic [3:0] hold_cnt_q;
  assign hold_expired = (hold_cnt_q == HOLD_LAST);
`else
  assign hold_expired = 1'b0;
`endif

  // The owner is masked from the scan so a hold-limit revoke always picks someone else.
  always_comb begin
    owner_mask = 4'b0001 << gnt_id_q;
    scan_req   = (state_q == S_GRANT) ? (req & ~owner_mask) : req;
    win        = ptr_q;
    win_found  = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!win_found && scan_req[2'(ptr_q + 2'(k))]) begin
        win       = 2'(ptr_q + 2'(k));
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    grant_new    = 1'b0;
    release_idle = 1'b0;
    if (state_q == S_IDLE) begin
      grant_new = win_found;
    end else if (!req[gnt_id_q]) begin
      grant_new    = win_found;
      release_idle = !win_found;
    end else begin
      grant_new = win_found && hold_expired;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
`ifdef RR_ARBITER_HOLD_LIMIT_EN
      hold_cnt_q  <= '0;
`endif
    end else if (grant_new) begin
      state_q     <= S_GRANT;
      gnt_id_q    <= win;
      gnt_valid_q <= 1'b1;
      ptr_q       <= 2'(win + 2'd1);
`ifdef RR_ARBITER_HOLD_LIMIT_EN
      hold_cnt_q  <= '0;
`endif
    end else if (release_idle) begin
      state_q     <= S_IDLE;
      gnt_valid_q <= 1'b0;
    end else if (state_q == S_GRANT) begin
`ifdef RR_ARBITER_HOLD_LIMIT_EN
      if (!hold_expired) begin
        hold_cnt_q <= hold_cnt_q + 4'd1;
      end
`endif
    end
  end

  assign gnt       = gnt_valid_q ? 4'(4'b0001 << gnt_id_q) : '0;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4: directed req vectors push expected grants, a monitor pops them.
// Hold-limit vectors are used when RR_ARBITER_HOLD_LIMIT_EN is defined (MAX_HOLD=4).
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;

  typedef struct {
    string      tag;
    logic       v;
    logic [1:0] id;
    logic [3:0] g;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

`ifdef RR_ARBITER_HOLD_LIMIT_EN
  rr_arbiter_4 #(.MAX_HOLD(4)) dut (
`else
  rr_arbiter_4 #(.MAX_HOLD(8)) dut (
`endif
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  function automatic void check(string tag, logic [6:0] act, logic [6:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got valid/id/gnt=%b/%b/%b, expected %b/%b/%b",
               tag, act[6], act[5:4], act[3:0], want[6], want[5:4], want[3:0]);
    end
  endfunction

  // Drive req for the next edge and queue the outputs expected after that edge.
  task automatic step(input string tag, input logic [3:0] r, input logic v, input logic [1:0] id);
    exp_t e;
    @(negedge clk);
    req  = r;
    e.tag = tag;
    e.v   = v;
    e.id  = id;
    e.g   = v ? 4'(4'b0001 << id) : 4'b0000;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.tag, {gnt_valid, gnt_id, gnt}, {e.v, e.id, e.g});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    #1 rst = 1'b1;
    #1 check("reset", {gnt_valid, gnt_id, gnt}, 7'b0_00_0000);
    @(negedge clk);
    rst = 1'b0;

    step("single_gnt",  4'b0001, 1'b1, 2'd0);
    step("single_rel",  4'b0000, 1'b0, 2'd0);
    step("idle_stay",   4'b0000, 1'b0, 2'd0);

    @(negedge clk);
    rst = 1'b1;
    #1 check("rst_pulse", {gnt_valid, gnt_id, gnt}, 7'b0_00_0000);
    @(negedge clk);
    rst = 1'b0;

    step("rot_0",       4'b1111, 1'b1, 2'd0);
    step("rot_0_hold",  4'b1111, 1'b1, 2'd0);
    step("rot_1",       4'b1110, 1'b1, 2'd1);
    step("rot_1_hold",  4'b1111, 1'b1, 2'd1);
    step("rot_2",       4'b1101, 1'b1, 2'd2);
    step("rot_2_hold",  4'b1111, 1'b1, 2'd2);
    step("rot_3",       4'b1011, 1'b1, 2'd3);
    step("rot_3_hold",  4'b1111, 1'b1, 2'd3);
    step("rot_wrap_0",  4'b0111, 1'b1, 2'd0);
    step("rot_0_again", 4'b1111, 1'b1, 2'd0);
    step("rot_idle",    4'b0000, 1'b0, 2'd0);

    step("wrap_set2",   4'b0100, 1'b1, 2'd2);
    step("wrap_rel2",   4'b0000, 1'b0, 2'd2);
    step("wrap_to_0",   4'b0101, 1'b1, 2'd0);
    step("wrap_to_2",   4'b0100, 1'b1, 2'd2);
    step("wrap_hold2",  4'b0100, 1'b1, 2'd2);

    @(negedge clk);
    #1 rst = 1'b1;
    req = 4'b0000;
    #1 check("async_rst", {gnt_valid, gnt_id, gnt}, 7'b0_00_0000);
    #1 rst = 1'b0;

    step("post_rst_2",  4'b1100, 1'b1, 2'd2);
    step("post_hold2",  4'b1100, 1'b1, 2'd2);
    step("post_to_3",   4'b1000, 1'b1, 2'd3);
    step("post_idle",   4'b0000, 1'b0, 2'd3);

`ifdef RR_ARBITER_HOLD_LIMIT_EN
    for (int i = 0; i < 10; i++) begin
      step($sformatf("hold_alt_%0d", i), 4'b0011, 1'b1, ((i / 4) % 2 == 1) ? 2'd1 : 2'd0);
    end
    for (int i = 0; i < 6; i++) begin
      step($sformatf("hold_solo_%0d", i), 4'b0001, 1'b1, 2'd0);
    end
`else
    for (int i = 0; i < 6; i++) begin
      step($sformatf("no_preempt_%0d", i), 4'b0011, 1'b1, 2'd0);
    end
`endif
    step("final_idle",  4'b0000, 1'b0, 2'd0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
